weight_mac_seq: RTL and testbench
=================================

// Module: weight_mac_seq
// PURPOSE
//  Downstream consumer of the 16x4 weight RAM. One start pulse runs one dot product.
//  For each of len elements it:
//   - drives raddr;
//   - reads back the 4-bit registered RAM dout (1-cycle read latency);
//   - takes one activation from a valid/ready stream;
//   - accumulates weight*activation.
//  Then it holds the sum until it is accepted. First compute stage of the ML datapath.
// PARAMETERS
//  DATA_W  4   weight/activation width (unsigned)
//  ADDR_W  4   weight RAM address width; max len = 2**ADDR_W
//  ACC_W   12  accumulator/result width; saturates at 2**ACC_W-1
// PORTS
//  CLOCK_50   in   1         sole clock, all state on posedge
//  rst_n      in   1         async active-low reset
//  start      in   1         1-cycle request; accepted only in IDLE
//  len        in   ADDR_W+1  element count 0..16, sampled on accepted start
//  mem_raddr  out  ADDR_W    weight RAM read address
//  mem_rd_en  out  1         read enable to RAM (RAM sw input); high in FETCH/WAIT
//  mem_dout   in   DATA_W    RAM read data; valid 1 cycle after raddr+rd_en
//  act_data   in   DATA_W    activation value
//  act_valid  in   1         activation present
//  act_ready  out  1         activation consumed this cycle (valid & ready)
//  busy       out  1         high in every state except IDLE
//  res_data   out  ACC_W     dot-product result, stable while res_valid
//  res_valid  out  1         result available
//  res_ready  in   1         result consumed when res_valid & res_ready
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; idx/acc/res_data/mem_raddr=0;
//   - mem_rd_en/act_ready/res_valid/busy=0.
//  States IDLE, FETCH, WAIT, MAC, DONE:
//   - IDLE: on start & len!=0 -> FETCH, latch len, idx=0, acc=0.
//           On start & len==0 -> DONE with res_data=0. Otherwise stay.
//   - FETCH: mem_raddr=idx, mem_rd_en=1 -> WAIT.
//   - WAIT: rd_en held 1; capture mem_dout into weight reg at end of cycle -> MAC.
//   - MAC: act_ready=1 (combinational, MAC only). If act_valid: acc+=weight*act_data, then:
//       - idx==len-1 -> DONE, res_data = updated acc;
//       - else idx++, -> FETCH.
//     If !act_valid: stay in MAC; weight reg held.
//   - DONE: res_valid=1; on res_ready -> IDLE, res_valid drops next cycle.
//  Cost and latency:
//   - 3 cycles per element with no stalls.
//   - res_valid rises 3*len+1 cycles after the start edge.
//  Arithmetic:
//   - product is 2*DATA_W bits unsigned, zero-extended.
//   - sum saturates to 2**ACC_W-1 and never wraps. At defaults 16*15*15=3600 fits, no saturation.
//  Boundaries:
//   - start outside IDLE is ignored; len is not re-sampled.
//   - idx never exceeds len-1; len=16 ends at idx=15 with no address wrap.
//   - res_ready outside DONE is ignored.
//   - act_valid outside MAC: no handshake, data not consumed.
//   - rst_n low mid-operation aborts immediately. Partial acc is discarded and no result is produced.
// STRUCTURE
//  Shared package:
//   - state encoding (IDLE=0, FETCH=1, WAIT=2, MAC=3, DONE=4);
//   - default DATA_W/ADDR_W/ACC_W constants.
//  One natural sub-module: sat_accum (ACC_W adder with unsigned saturation).
//  FSM, idx counter and handshakes stay in this module.
// TESTING
//  1. Preload w[i]=i; len=16, act always 2, res_ready=1
//     -> res_data=240; res_valid at cycle 49 after start.
//  2. All weights 15, all acts 15, len=16 -> res_data=3600, no saturation.
//  3. len=0 start -> res_valid next cycle with res_data=0; no mem_rd_en pulse.
//  4. w[0..3]=1,2,3,4; acts 4,3,2,1 with act_valid low 5 cycles before element 2
//     -> res_data=20; MAC holds, acc unchanged during stall.
//  5. ACC_W=8, weights 15, acts 15, len=2 -> res_data=255 (saturated).
//  6. Disturbances:
//     - start pulsed during busy -> ignored;
//     - rst_n low at idx=5 -> all outputs reset value;
//     - new start then runs cleanly from idx=0.

Source files
------------

// File: rtl/weight_mac_seq_pkg.sv
// Shared definitions for the weight MAC sequencer.
//   state_t     : FSM state encoding (IDLE=0, FETCH=1, WAIT=2, MAC=3, DONE=4)
//   DEF_*       : default widths for weights/activations, RAM address, accumulator
package weight_mac_seq_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_ACC_W  = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_MAC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/weight_mac_seq_sat_accum.sv
// Unsigned saturating adder used as the MAC accumulator stage.
//   acc_in  : current accumulator value (ACC_W bits)
//   addend  : zero-extended product to add (ADD_W bits)
//   sum_out : acc_in + addend, clamped to 2**ACC_W-1 (never wraps)
module sat_accum
  import weight_mac_seq_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned ADD_W = 2 * DEF_DATA_W
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [ADD_W-1:0] addend,
  output logic [ACC_W-1:0] sum_out
);

  // One guard bit above the wider operand catches every overflow.
  localparam int unsigned SUM_W = ((ACC_W > ADD_W) ? ACC_W : ADD_W) + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(acc_in) + SUM_W'(addend);
    if (sum > SAT_MAX) begin
      sum_out = '1;
    end else begin
      sum_out = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/weight_mac_seq.sv
// Weight MAC sequencer: one start pulse runs a len-element dot product of
// weights read from a registered 16x4 RAM with activations from a
// valid/ready stream, then holds the saturated sum until accepted.
//   CLOCK_50  : clock            rst_n     : async active-low reset
//   start/len : job request, len sampled on accepted start (0..2**ADDR_W)
//   mem_raddr/mem_rd_en/mem_dout : weight RAM read port (1-cycle latency)
//   act_data/act_valid/act_ready : activation stream (ready only in MAC)
//   busy      : high in every state except IDLE
//   res_data/res_valid/res_ready : result handshake
module weight_mac_seq
  import weight_mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] act_data,
  input  logic              act_valid,
  output logic              act_ready,
  output logic              busy,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   weight;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [2*DATA_W-1:0] prod;
  logic                last_elem;

  assign act_ready = (state == S_MAC);
  assign prod      = (2*DATA_W)'(weight) * (2*DATA_W)'(act_data);
  assign last_elem = (((ADDR_W+1)'(idx) + (ADDR_W+1)'(1)) == len_q);

  sat_accum #(
    .ACC_W (ACC_W),
    .ADD_W (2*DATA_W)
  ) u_sat_accum (
    .acc_in  (acc),
    .addend  (prod),
    .sum_out (acc_next)
  );

  // mem_raddr/mem_rd_en are registered: they are loaded on the edge that
  // enters FETCH so the RAM sees them throughout FETCH and WAIT.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      idx       <= '0;
      weight    <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      mem_raddr <= '0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            acc  <= '0;
            idx  <= '0;
            if (len != '0) begin
              len_q     <= len;
              mem_raddr <= '0;
              mem_rd_en <= 1'b1;
              state     <= S_FETCH;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          weight    <= mem_dout;
          mem_rd_en <= 1'b0;
          state     <= S_MAC;
        end
        S_MAC: begin
          if (act_valid) begin
            acc <= acc_next;
            if (last_elem) begin
              res_data  <= acc_next;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx       <= idx + ADDR_W'(1);
              mem_raddr <= idx + ADDR_W'(1);
              mem_rd_en <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mac_seq.sv
module tb_weight_mac_seq;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic [3:0]  mem_raddr;
  logic        mem_rd_en;
  logic [3:0]  mem_dout;
  logic [3:0]  act_data;
  logic        act_valid;
  logic        act_ready;
  logic        busy;
  logic [11:0] res_data;
  logic        res_valid;
  logic        res_ready;

  // second instance with a narrow accumulator for the saturation case
  logic        s8_start;
  logic [4:0]  s8_len;
  logic [3:0]  s8_raddr;
  logic        s8_rd_en;
  logic [3:0]  s8_dout;
  logic [3:0]  s8_act_data;
  logic        s8_act_valid;
  logic        s8_act_ready;
  logic        s8_busy;
  logic [7:0]  s8_res_data;
  logic        s8_res_valid;
  logic        s8_res_ready;

  weight_mac_seq #(.DATA_W(4), .ADDR_W(4), .ACC_W(12)) dut (
    .CLOCK_50 (CLOCK_50), .rst_n (rst_n), .start (start), .len (len),
    .mem_raddr (mem_raddr), .mem_rd_en (mem_rd_en), .mem_dout (mem_dout),
    .act_data (act_data), .act_valid (act_valid), .act_ready (act_ready),
    .busy (busy), .res_data (res_data), .res_valid (res_valid), .res_ready (res_ready)
  );

  weight_mac_seq #(.DATA_W(4), .ADDR_W(4), .ACC_W(8)) dut8 (
    .CLOCK_50 (CLOCK_50), .rst_n (rst_n), .start (s8_start), .len (s8_len),
    .mem_raddr (s8_raddr), .mem_rd_en (s8_rd_en), .mem_dout (s8_dout),
    .act_data (s8_act_data), .act_valid (s8_act_valid), .act_ready (s8_act_ready),
    .busy (s8_busy), .res_data (s8_res_data), .res_valid (s8_res_valid), .res_ready (s8_res_ready)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // registered weight RAM models (1-cycle read latency)
  logic [3:0] wmem [16];
  always @(posedge CLOCK_50) if (mem_rd_en) mem_dout <= wmem[mem_raddr];
  always @(posedge CLOCK_50) if (s8_rd_en) s8_dout <= wmem[s8_raddr];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic fail_note(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // scoreboard + activity monitors (sampled on negedge, away from posedge)
  logic [11:0] sb_q[$];
  int unsigned rd_cnt = 0, stall_cnt = 0;
  logic [3:0]  last_raddr = '0;

  always @(negedge CLOCK_50) begin
    if (mem_rd_en) begin
      rd_cnt++;
      last_raddr = mem_raddr;
    end
    if (act_ready && !act_valid) stall_cnt++;
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got result %0d expected none", res_data);
      end else begin
        check("sb_result", 32'(res_data), 32'(sb_q.pop_front()));
      end
    end
  end

  logic [3:0]  act_seq   [16];
  int unsigned stall_seq [16];
  logic        abort_feed = 1'b0;

  task automatic feed_acts(input int unsigned n);
    int unsigned guard;
    for (int unsigned k = 0; k < n; k++) begin
      if (abort_feed) break;
      if (stall_seq[k] > 0) begin
        act_valid = 1'b0;
        repeat (stall_seq[k]) @(posedge CLOCK_50);
        #1;
      end
      act_data  = act_seq[k];
      act_valid = 1'b1;
      guard = 0;
      while (!act_ready && !abort_feed && guard < 100) begin
        @(negedge CLOCK_50);
        guard++;
      end
      if (abort_feed) break;
      if (!act_ready) begin
        fail_note("act_handshake");
        break;
      end
      @(posedge CLOCK_50);
      #1;
    end
    act_valid = 1'b0;
  endtask

  // Runs one job; lat = edges from the accepting edge (counted as 1) until res_valid.
  task automatic run_job(input int unsigned n, input int unsigned exp, input int unsigned hold,
                         input int unsigned ghost_at, output int unsigned lat);
    int unsigned cyc = 0;
    int unsigned guard;
    @(negedge CLOCK_50);
    start     = 1'b1;
    len       = 5'(n);
    res_ready = (hold == 0);
    sb_q.push_back(12'(exp));
    fork
      feed_acts(n);
      begin
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 200) begin
          if (cyc == ghost_at) begin
            start = 1'b1;
            len   = 5'd3;
          end else begin
            start = 1'b0;
          end
          @(posedge CLOCK_50); #1;
          cyc++;
        end
        start = 1'b0;
      end
    join
    lat = cyc;
    if (hold > 0) begin
      repeat (hold) @(posedge CLOCK_50);
      #1;
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", 32'(res_data), 32'(exp));
      res_ready = 1'b1;
    end
    guard = 0;
    while (busy && guard < 50) begin
      @(posedge CLOCK_50); #1;
      guard++;
    end
    if (busy) fail_note("busy_release");
    check("res_valid_drop", 32'(res_valid), 32'd0);
  endtask

  typedef struct {
    int unsigned len;
    int unsigned wmode;   // 0: w[i]=i, 1: all weights = wval
    logic [3:0]  wval;
    logic [3:0]  act;
    int unsigned exp_res;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int unsigned lat, rd0, st0, guard;
    vecs[0] = '{16, 0, 4'd0,  4'd2,  240};
    vecs[1] = '{16, 1, 4'd15, 4'd15, 3600};
    vecs[2] = '{0,  1, 4'd0,  4'd5,  0};
    vecs[3] = '{5,  1, 4'd3,  4'd7,  105};
    vecs[4] = '{1,  1, 4'd9,  4'd9,  81};
    vecs[5] = '{10, 0, 4'd0,  4'd1,  45};

    rst_n = 1'b0; start = 1'b0; len = '0; act_data = '0; act_valid = 1'b0; res_ready = 1'b1;
    s8_start = 1'b0; s8_len = '0; s8_act_data = 4'd15; s8_act_valid = 1'b1; s8_res_ready = 1'b1;
    for (int i = 0; i < 16; i++) wmem[i] = 4'(i);
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_act_ready", 32'(act_ready), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // table-driven jobs
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 16; j++) begin
        wmem[j]      = (vecs[i].wmode == 0) ? 4'(j) : vecs[i].wval;
        act_seq[j]   = vecs[i].act;
        stall_seq[j] = 0;
      end
      rd0 = rd_cnt;
      run_job(vecs[i].len, vecs[i].exp_res, 0, 0, lat);
      check($sformatf("row%0d_latency", i), lat, 3 * vecs[i].len + 1);
      check($sformatf("row%0d_rd_cycles", i), rd_cnt - rd0, 2 * vecs[i].len);
      if (vecs[i].len > 0)
        check($sformatf("row%0d_last_raddr", i), 32'(last_raddr), vecs[i].len - 1);
    end

    // saturation with a narrow accumulator: 225 + 225 clamps to 255
    for (int j = 0; j < 16; j++) wmem[j] = 4'd15;
    @(negedge CLOCK_50);
    s8_start = 1'b1;
    s8_len   = 5'd2;
    @(posedge CLOCK_50); #1;
    s8_start = 1'b0;
    lat = 1;
    while (!s8_res_valid && lat < 100) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    check("sat8_latency", lat, 7);
    check("sat8_res", 32'(s8_res_data), 32'd255);
    repeat (2) @(negedge CLOCK_50);

    // activation stall before element 2, result held 3 cycles before acceptance
    wmem[0] = 4'd1; wmem[1] = 4'd2; wmem[2] = 4'd3; wmem[3] = 4'd4;
    act_seq[0] = 4'd4; act_seq[1] = 4'd3; act_seq[2] = 4'd2; act_seq[3] = 4'd1;
    for (int j = 0; j < 16; j++) stall_seq[j] = (j == 2) ? 5 : 0;
    st0 = stall_cnt;
    run_job(4, 20, 3, 0, lat);
    check("stall_mac_cycles", stall_cnt - st0, 3);
    check("stall_latency", lat, 16);
    for (int j = 0; j < 16; j++) stall_seq[j] = 0;

    // start pulsed mid-job is ignored; len is not re-sampled
    for (int j = 0; j < 16; j++) begin
      wmem[j]    = 4'(j);
      act_seq[j] = 4'd1;
    end
    run_job(8, 28, 0, 10, lat);
    check("ghost_start_latency", lat, 25);
    check("ghost_start_last_raddr", 32'(last_raddr), 32'd7);

    // reset asserted at idx=5 aborts the job with no result
    @(negedge CLOCK_50);
    start = 1'b1;
    len   = 5'd16;
    sb_q.push_back(12'd120);
    fork
      feed_acts(16);
      begin
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        guard = 0;
        while (!(mem_rd_en && mem_raddr == 4'd5) && guard < 100) begin
          @(negedge CLOCK_50);
          guard++;
        end
        check("abort_reached_idx5", 32'(mem_raddr), 32'd5);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_raddr", 32'(mem_raddr), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_data", 32'(res_data), 32'd0);
        check("abort_act_ready", 32'(act_ready), 32'd0);
        abort_feed = 1'b1;
      end
    join
    sb_q.delete();
    act_valid = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    abort_feed = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("post_abort_res_valid", 32'(res_valid), 32'd0);
    check("post_abort_busy", 32'(busy), 32'd0);

    rd0 = rd_cnt;
    run_job(4, 6, 0, 0, lat);
    check("rerun_latency", lat, 13);
    check("rerun_rd_cycles", rd_cnt - rd0, 8);
    check("rerun_last_raddr", 32'(last_raddr), 32'd3);
    check("sb_drained", sb_q.size(), 0);

    repeat (2) @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
